tc_clk_div: RTL and testbench
=============================

TC_CLK_DIV -- requirements
Module: tc_clk_div

Interface
REQ-001 SHALL have parameter DivWidth, default 8: width of divisor and internal counter.
REQ-002 SHALL have parameter DefaultDiv, default 1: divisor loaded at reset; 0 and 1 both mean bypass.
REQ-003 SHALL have port clk_i  input  1: single source clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port en_i  input  1: run request for the output clock.
REQ-006 SHALL have port test_mode_i  input  1: forces clk_o = clk_i, overriding en_i and divisor.
REQ-007 SHALL have port div_i  input  DivWidth: requested divisor, unsigned.
REQ-008 SHALL have port div_valid_i  input  1: divisor update request.
REQ-009 SHALL have port div_ready_o  output  1: divisor update may be accepted this cycle.
REQ-010 SHALL have port clk_o  output  1: divided / bypassed / gated clock.
REQ-011 SHALL have port tick_o  output  1: one-clk_i-cycle pulse on each cycle in which the divided clock rises.

Function
REQ-012 SHALL hold a registered divisor div_q, counter cnt_q (DivWidth bits), run flag run_q and output register clk_q.
REQ-013 SHALL, in divide mode (div_q >= 2, run_q = 1), count cnt_q 0..div_q-1 then wrap to 0; the last count is the wrap cycle.
REQ-014 SHALL drive clk_q = 1 while cnt_q < (div_q >> 1), else 0; period = div_q clk_i cycles, high time = floor(div_q/2) cycles (div 2: 1/1, div 3: 1/2, div 255: 127/128).
REQ-015 SHALL make clk_o in divide mode come only from clk_q (no combinational path from counter).
REQ-016 SHALL, in bypass mode (div_q <= 1), drive clk_o = clk_i gated by run_q through the codebase clock-gating cell (latch-based, enable transparent while clk_i low).
REQ-017 SHALL set run_q = 1 on the first rising edge with en_i = 1 while run_q = 0, starting at cnt_q = 0 (clk_o high in the following cycle for divide mode).
REQ-018 SHALL, on en_i = 0 while running, finish the current divided period and clear run_q at the wrap cycle; in bypass, clear run_q on the next rising edge.
REQ-019 SHALL, when run_q = 0, hold cnt_q = 0 and clk_o = 0 (test_mode_i = 0).
REQ-020 SHALL assert div_ready_o when run_q = 0, or div_q <= 1, or cnt_q == div_q-1 (wrap cycle); otherwise 0.
REQ-021 SHALL accept div_i on a rising edge with div_valid_i & div_ready_o: div_q <= div_i, cnt_q <= 0 from the next cycle; no truncated high or low phase is produced.
REQ-022 SHALL ignore div_valid_i while div_ready_o = 0; the requester holds div_valid_i and div_i stable until accepted.
REQ-023 SHALL, on simultaneous update acceptance and en_i deassertion at wrap, load div_q and clear run_q.
REQ-024 SHALL pulse tick_o for one cycle when cnt_q == 0 and run_q = 1 in divide mode, every clk_i cycle in running bypass mode, never when run_q = 0.
REQ-025 SHALL leave all registers running normally under test_mode_i = 1; only the clk_o mux is overridden.

Reset
REQ-026 SHALL, while rst_ni = 0, force div_q = DefaultDiv, cnt_q = 0, run_q = 0, clk_q = 0, clk_o = 0, tick_o = 0, div_ready_o = 1.
REQ-027 SHALL, on reset assertion mid-period, drop clk_o to 0 immediately (asynchronously) and restart from REQ-017 after release.

Verification
REQ-028 SHALL cover: reset release, div_i = 4 accepted, en_i = 1 -> clk_o 2 high / 2 low clk_i cycles, tick_o every 4th cycle.
REQ-029 SHALL cover: running div 5, request div 2 at cnt_q = 1 -> div_ready_o = 0 until cnt_q = 4, then period 2 with 1/1 duty, no pulse shorter than 1 cycle.
REQ-030 SHALL cover: running div 3, en_i = 0 at cnt_q = 0 -> period completes (clk_o low for cnt 1,2), then clk_o = 0 and tick_o = 0.
REQ-031 SHALL cover: div 0 and div 1 with en_i = 1 -> clk_o = clk_i, glitch-free when en_i toggles while clk_i high.
REQ-032 SHALL cover: test_mode_i = 1 with en_i = 0, div 8 -> clk_o = clk_i; deassert -> clk_o = 0.
REQ-033 SHALL cover: rst_ni low at cnt_q = 2 of div 6 -> clk_o = 0 in same cycle, div_q = DefaultDiv, div_ready_o = 1.

Source files
------------

// File: rtl/tc_clk_div.sv
// tc_clk_div: programmable clock divider with bypass, run/stop control,
// glitch-free divisor updates and a test-mode clock override.
// Divide mode (div_q >= 2) drives clk_o from a register only.
// Bypass mode (div_q <= 1) drives clk_o from clk_i through a latch-based gate.
module tc_clk_div #(
    parameter int unsigned DivWidth   = 8,
    parameter int unsigned DefaultDiv = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                test_mode_i,
    input  logic [DivWidth-1:0] div_i,
    input  logic                div_valid_i,
    output logic                div_ready_o,
    output logic                clk_o,
    output logic                tick_o
);

    localparam logic [DivWidth-1:0] DivReset = DivWidth'(DefaultDiv);
    localparam logic [DivWidth-1:0] One      = DivWidth'(1);

    logic [DivWidth-1:0] div_q, div_d;
    logic [DivWidth-1:0] cnt_q, cnt_d;
    logic                run_q, run_d;
    logic                clk_q, clk_d;
    logic                divide_mode;
    logic                last_cnt;
    logic                wrap;
    logic                accept;
    logic                en_latch;
    logic                gated_clk;

    // A divisor of 0 or 1 selects bypass; anything larger divides.
    assign divide_mode = (div_q > One);
    assign last_cnt    = (cnt_q == div_q - One);
    assign wrap        = run_q & divide_mode & last_cnt;

    // Updates are only taken at period boundaries, so no phase is ever cut short.
    assign div_ready_o = ~run_q | ~divide_mode | last_cnt;
    assign accept      = div_valid_i & div_ready_o;

    // Rising-edge marker of the divided clock (every cycle in running bypass).
    assign tick_o      = run_q & (~divide_mode | (cnt_q == '0));

    // Next-state computation for divisor, run flag, counter and clock register.
    always_comb begin
        // NOTE: every output of this block is assigned on every path, so no latch is inferred.
        div_d = accept ? div_i : div_q;

        if (!run_q || !divide_mode) begin
            run_d = en_i;
        end else if (wrap) begin
            run_d = en_i;
        end else begin
            run_d = 1'b1;
        end

        if (!run_d || !run_q || accept || !divide_mode || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + One;
        end

        // Register the clock level for the upcoming count, so clk_o has no
        // combinational path from the counter.
        clk_d = run_d & (div_d > One) & (cnt_d < (div_d >> 1));
    end

    // State registers, asynchronously reset to the idle configuration.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_ni) begin
            div_q <= DivReset;
            cnt_q <= '0;
            run_q <= 1'b0;
            clk_q <= 1'b0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            clk_q <= clk_d;
        end
    end

    // Clock-gate enable latch: transparent while clk_i is low, so the gated clock
    // can only start or stop on a rising edge and never glitches in the high phase.
    always_latch begin
        // NOTE: this latch is intentional; it is the enable stage of the clock gate.
        if (!rst_ni) begin
            en_latch <= 1'b0;
        end else if (!clk_i) begin
            en_latch <= run_d;
        end
    end

    assign gated_clk = clk_i & en_latch;

    // Output clock select: test override, then divided register or gated bypass.
    assign clk_o = test_mode_i ? clk_i : (divide_mode ? clk_q : gated_clk);

endmodule

// File: tb/tb_tc_clk_div.sv
// tb_tc_clk_div: directed bench for tc_clk_div with a period-position model.
module tb_tc_clk_div;

    localparam int DW      = 8;
    localparam int DEF_DIV = 1;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          en_i;
    logic          test_mode_i;
    logic [DW-1:0] div_i;
    logic          div_valid_i;
    logic          div_ready_o;
    logic          clk_o;
    logic          tick_o;

    tc_clk_div #(.DivWidth(DW), .DefaultDiv(DEF_DIV)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .test_mode_i (test_mode_i),
        .div_i       (div_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .clk_o       (clk_o),
        .tick_o      (tick_o)
    );

    // Edges of clk_i fall on multiples of 5 time units.
    always #5 clk_i = ~clk_i;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  chk_en   = 1'b0;
    int  glitches = 0;
    time t_exempt = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    endtask

    // Model: the divided clock is a sequence of whole periods; the position inside
    // the current period is the number of cycles since that period started.
    int m_div   = DEF_DIV;
    bit m_run   = 1'b0;
    int cyc     = 0;
    int m_start = 0;
    bit mdv, mlast, mrdy, mnrun;
    int mpos;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_div   = DEF_DIV;
            m_run   = 1'b0;
            m_start = cyc;
        end else begin
            mdv   = (m_div >= 2);
            mpos  = (m_run && mdv) ? (cyc - m_start) % m_div : 0;
            mlast = m_run && mdv && (mpos == m_div - 1);
            mrdy  = !m_run || !mdv || mlast;
            if (!m_run || !mdv) mnrun = en_i;
            else                mnrun = mlast ? en_i : 1'b1;
            if (!(m_run && mdv && !mlast)) m_start = cyc + 1;
            if (div_valid_i && mrdy) m_div = int'(div_i);
            m_run = mnrun;
            cyc++;
        end
    end

    task automatic cmp(input bit high);
        bit dv;
        int pos;
        int e_clk, e_tick, e_rdy;
        dv  = (m_div >= 2);
        pos = (m_run && dv) ? (cyc - m_start) % m_div : 0;
        e_rdy  = (!m_run || !dv || pos == m_div - 1) ? 1 : 0;
        e_tick = (m_run && (!dv || pos == 0)) ? 1 : 0;
        if (test_mode_i)  e_clk = high ? 1 : 0;
        else if (!m_run)  e_clk = 0;
        else if (dv)      e_clk = (pos < m_div / 2) ? 1 : 0;
        else              e_clk = high ? 1 : 0;
        check(high ? "model_clk_o_hi" : "model_clk_o_lo", clk_o, e_clk);
        check("model_tick_o", tick_o, e_tick);
        check("model_div_ready_o", div_ready_o, e_rdy);
    endtask

    // Single compare process: one sample in each half of every clk_i cycle.
    always begin
        @(posedge clk_i);
        #1;
        if (chk_en) cmp(1'b1);
        @(negedge clk_i);
        #1;
        if (chk_en) cmp(1'b0);
    end

    // Any clk_o change away from a clk_i edge (other than reset assertion) is a glitch.
    always @(clk_o) begin
        if (chk_en && ($time % 5) != 0 && $time != t_exempt) glitches++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic tick_wait();
        @(negedge clk_i);
        #2;
    endtask

    int pat_clk[8]  = '{1, 1, 0, 0, 1, 1, 0, 0};
    int pat_tick[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
    int pat_rdy[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};

    initial begin
        rst_ni = 1'b0; en_i = 1'b0; test_mode_i = 1'b0;
        div_i = '0; div_valid_i = 1'b0;
        repeat (2) tick_wait();
        check("rst_clk_o", clk_o, 0);
        check("rst_tick_o", tick_o, 0);
        check("rst_div_ready_o", div_ready_o, 1);
        rst_ni = 1'b1;
        chk_en = 1'b1;

        // Divide by 4: 2 high / 2 low, tick every 4th cycle.
        div_i = 8'd4; div_valid_i = 1'b1;
        tick_wait();
        div_valid_i = 1'b0; en_i = 1'b1;
        check("div4_idle_clk", clk_o, 0);
        for (int i = 0; i < 8; i++) begin
            tick_wait();
            check($sformatf("div4_clk[%0d]", i), clk_o, pat_clk[i]);
            check($sformatf("div4_tick[%0d]", i), tick_o, pat_tick[i]);
            check($sformatf("div4_ready[%0d]", i), div_ready_o, pat_rdy[i]);
        end

        // Divide by 5, then request 2 mid-period; it must wait for the wrap.
        div_i = 8'd5; div_valid_i = 1'b1;
        tick_wait();
        div_valid_i = 1'b0;
        check("div5_p0_clk", clk_o, 1);
        check("div5_p0_tick", tick_o, 1);
        tick_wait();
        check("div5_p1_clk", clk_o, 1);
        div_i = 8'd2; div_valid_i = 1'b1;
        for (int p = 2; p <= 4; p++) begin
            tick_wait();
            check($sformatf("div5_p%0d_ready", p), div_ready_o, (p == 4) ? 1 : 0);
            check($sformatf("div5_p%0d_clk", p), clk_o, 0);
        end
        tick_wait();
        div_valid_i = 1'b0;
        check("div2_p0_clk", clk_o, 1);
        check("div2_p0_tick", tick_o, 1);
        check("div2_p0_ready", div_ready_o, 0);
        tick_wait();
        check("div2_p1_clk", clk_o, 0);
        check("div2_p1_ready", div_ready_o, 1);
        tick_wait();
        check("div2_p0b_clk", clk_o, 1);
        tick_wait();
        div_i = 8'd3; div_valid_i = 1'b1;

        // Divide by 3, stop requested at count 0: period completes, then idle.
        tick_wait();
        div_valid_i = 1'b0;
        check("div3_p0_clk", clk_o, 1);
        check("div3_p0_tick", tick_o, 1);
        en_i = 1'b0;
        tick_wait();
        check("div3_p1_clk", clk_o, 0);
        check("div3_p1_ready", div_ready_o, 0);
        tick_wait();
        check("div3_p2_clk", clk_o, 0);
        check("div3_p2_ready", div_ready_o, 1);
        tick_wait();
        check("div3_stop_clk", clk_o, 0);
        check("div3_stop_tick", tick_o, 0);
        tick_wait();
        check("div3_stop2_tick", tick_o, 0);

        // Bypass with divisor 0; enable toggled during clk_i high phases.
        div_i = 8'd0; div_valid_i = 1'b1;
        tick_wait();
        div_valid_i = 1'b0;
        check("byp0_idle_tick", tick_o, 0);
        @(posedge clk_i);
        #3 en_i = 1'b1;
        #1 check("byp0_en_in_hi_clk", clk_o, 0);
        @(posedge clk_i);
        #1 check("byp0_first_hi_clk", clk_o, 1);
        check("byp0_first_tick", tick_o, 1);
        @(negedge clk_i);
        #1 check("byp0_lo_clk", clk_o, 0);
        repeat (2) @(posedge clk_i);
        #3 en_i = 1'b0;
        #1 check("byp0_off_in_hi_clk", clk_o, 1);
        @(posedge clk_i);
        #1 check("byp0_stopped_clk", clk_o, 0);
        check("byp0_stopped_tick", tick_o, 0);

        // Bypass with divisor 1, started together with the update.
        tick_wait();
        div_i = 8'd1; div_valid_i = 1'b1; en_i = 1'b1;
        @(posedge clk_i);
        #1 check("byp1_hi_clk", clk_o, 1);
        check("byp1_tick", tick_o, 1);
        div_valid_i = 1'b0;
        @(negedge clk_i);
        #1 check("byp1_lo_clk", clk_o, 0);
        @(posedge clk_i);
        #1 check("byp1_hi2_clk", clk_o, 1);
        tick_wait();
        en_i = 1'b0;
        tick_wait();
        check("byp1_stop_tick", tick_o, 0);

        // Test mode overrides a stopped divide-by-8.
        div_i = 8'd8; div_valid_i = 1'b1;
        tick_wait();
        div_valid_i = 1'b0; test_mode_i = 1'b1;
        @(posedge clk_i);
        #1 check("tm_hi_clk", clk_o, 1);
        @(negedge clk_i);
        #1 check("tm_lo_clk", clk_o, 0);
        check("tm_tick", tick_o, 0);
        @(posedge clk_i);
        #1 check("tm_hi2_clk", clk_o, 1);
        tick_wait();
        test_mode_i = 1'b0;
        @(posedge clk_i);
        #1 check("tm_off_clk", clk_o, 0);

        // Divide by 6, reset asserted while high at count 2.
        tick_wait();
        div_i = 8'd6; div_valid_i = 1'b1; en_i = 1'b1;
        tick_wait();
        div_valid_i = 1'b0;
        check("div6_p0_clk", clk_o, 1);
        repeat (2) tick_wait();
        check("div6_p2_clk", clk_o, 1);
        t_exempt = $time;
        rst_ni = 1'b0;
        #1;
        check("rst_async_clk", clk_o, 0);
        check("rst_async_ready", div_ready_o, 1);
        check("rst_async_tick", tick_o, 0);
        repeat (2) tick_wait();
        rst_ni = 1'b1;
        // Default divisor is bypass; en_i is still high so the clock restarts.
        @(posedge clk_i);
        #1 check("restart_hi_clk", clk_o, 1);
        check("restart_tick", tick_o, 1);
        repeat (3) tick_wait();
        en_i = 1'b0;
        repeat (3) tick_wait();

        check("no_glitches", glitches, 0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
